// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Bundle of signals between the two ALU requesters, the shared combinational
// ALU and the alu_arbiter sequencer.
//   req0/req1, op0/op1, a0/b0/a1/b1 : requests and operands (requesters -> arbiter)
//   gnt0/gnt1                       : one-cycle accept pulses (arbiter -> requesters)
//   alu_ctrl/alu_a/alu_b            : ALU operation and operands (arbiter -> ALU)
//   alu_zhi/alu_zlow                : ALU result (ALU -> arbiter)
//   res_hi/res_lo, done, done_id, err, busy : results and status (arbiter -> requesters)
// The slave modport is the arbiter's view. The master modport is the view of
// everything around the arbiter (both requesters plus the ALU).
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [4:0]  op0;
  logic [4:0]  op1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_zhi;
  logic [31:0] alu_zlow;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        done;
  logic        done_id;
  logic        err;
  logic        busy;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_zhi, alu_zlow,
    output gnt0, gnt1, alu_ctrl, alu_a, alu_b, res_hi, res_lo,
           done, done_id, err, busy
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_zhi, alu_zlow,
    input  gnt0, gnt1, alu_ctrl, alu_a, alu_b, res_hi, res_lo,
           done, done_id, err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter and sequencer for the shared combinational ALU.
// One request is accepted at a time from port 0 (instruction datapath) or
// port 1 (address/branch unit). The operation is held on the ALU for an
// op-dependent number of cycles. The result is then captured and completion
// is signalled with a one-cycle done pulse tagged with the owner's port.
// Ports:
//   clk : clock, all state changes on the rising edge
//   clr : synchronous active-low reset
//   bus : alu_arbiter_if.slave (requests, grants, ALU drive, results, status)
// Parameters:
//   MUL_CYCLES : EXEC cycles for multiply (op 2), 1..15
//   DIV_CYCLES : EXEC cycles for divide   (op 3), 1..15
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic          clk,
  input  logic          clr,
  alu_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter is loaded with L-1 so that it reads 0 on the last EXEC cycle.
  localparam logic [3:0] MUL_LAT_M1 = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAT_M1 = 4'(DIV_CYCLES - 1);

  // Illegal op code, or a divide whose divisor is zero.
  function automatic logic op_is_bad(input logic [4:0] op, input logic [31:0] b);
    return (op > 5'd11) || ((op == 5'd3) && (b == 32'd0));
  endfunction

  // Counter preload (L-1) for an accepted op; errors finish after one cycle.
  function automatic logic [3:0] op_lat_m1(input logic [4:0] op, input logic bad);
    logic [3:0] lat;
    if (bad) begin
      lat = 4'd0;
    end else begin
      case (op)
        5'd2:    lat = MUL_LAT_M1;
        5'd3:    lat = DIV_LAT_M1;
        default: lat = 4'd0;
      endcase
    end
    return lat;
  endfunction

  logic [1:0]  state_q,    state_d;
  logic        prio_q,     prio_d;
  logic        sel_q,      sel_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [4:0]  ctrl_q,     ctrl_d;
  logic [31:0] a_q,        a_d;
  logic [31:0] b_q,        b_d;
  logic        bad_q,      bad_d;
  logic        gnt0_q,     gnt0_d;
  logic        gnt1_q,     gnt1_d;
  logic        done_q,     done_d;
  logic        done_id_q,  done_id_d;
  logic        err_q,      err_d;
  logic [31:0] res_hi_q,   res_hi_d;
  logic [31:0] res_lo_q,   res_lo_d;

  logic        sel_s;
  logic [4:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        bad_s;

  // Arbitration: a lone request wins outright; contention goes to prio.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      sel_s = prio_q;
    end else if (bus.req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    op_s  = sel_s ? bus.op1 : bus.op0;
    a_s   = sel_s ? bus.a1  : bus.a0;
    b_s   = sel_s ? bus.b1  : bus.b0;
    bad_s = op_is_bad(op_s, b_s);
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    bad_d     = bad_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ST_EXEC;
          sel_d   = sel_s;
          prio_d  = ~sel_s;
          cnt_d   = op_lat_m1(op_s, bad_s);
          ctrl_d  = op_s;
          a_d     = a_s;
          b_d     = b_s;
          bad_d   = bad_s;
          gnt0_d  = ~sel_s;
          gnt1_d  = sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_DONE;
          res_hi_d  = bad_q ? 32'd0 : bus.alu_zhi;
          res_lo_d  = bad_q ? 32'd0 : bus.alu_zlow;
          done_d    = 1'b1;
          done_id_d = sel_q;
          err_d     = bad_q;
          // ALU inputs return to zero as soon as EXEC ends.
          ctrl_d    = 5'd0;
          a_d       = 32'd0;
          b_d       = 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        ctrl_d  = 5'd0;
        a_d     = 32'd0;
        b_d     = 32'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      cnt_q     <= 4'd0;
      ctrl_q    <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      bad_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      bad_q     <= bad_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.alu_ctrl = ctrl_q;
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.res_hi   = res_hi_q;
  assign bus.res_lo   = res_lo_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 8;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU: {zHI, zLOW}. Divide gives {remainder, quotient}.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [5:0] s;
    s = {1'b0, b[4:0]};
    case (op)
      5'd0:  return {32'd0, a + b};
      5'd1:  return {32'd0, a - b};
      5'd2:  return {32'd0, a} * {32'd0, b};
      5'd3:  return (b == 32'd0) ? 64'hDEAD_BEEF_0BAD_F00D : {a % b, a / b};
      5'd4:  return {32'd0, a >> s};
      5'd5:  return {32'd0, a << s};
      5'd6:  return {32'd0, (a >> s) | (a << (6'd32 - s))};
      5'd7:  return {32'd0, (a << s) | (a >> (6'd32 - s))};
      5'd8:  return {32'd0, a & b};
      5'd9:  return {32'd0, a | b};
      5'd10: return {32'd0, 32'd0 - a};
      5'd11: return {32'd0, ~a};
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  always_comb {bus.alu_zhi, bus.alu_zlow} = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  // Behavioural rules: error condition and EXEC length.
  function automatic logic ref_err(input logic [4:0] op, input logic [31:0] b);
    return (int'(op) > 11) || (op == 5'd3 && b == 32'd0);
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
    if (ref_err(op, b)) return 1;
    if (op == 5'd2) return MUL_CYC;
    if (op == 5'd3) return DIV_CYC;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive_port(input int p, input logic r, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req0 = r; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = r; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
  endtask

  // Called at a negedge in IDLE with requests already driven; the next
  // posedge is the accept edge. Returns at the negedge of cycle L+2.
  task automatic check_txn(input logic win, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic e,
                           input logic [31:0] hi, input logic [31:0] lo);
    chk("c0_busy", 64'(bus.busy), 64'd0);
    chk("c0_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("c0_ops", {bus.alu_a, bus.alu_b}, 64'd0);
    @(posedge clk); @(negedge clk);
    chk("c1_gnt", 64'({bus.gnt1, bus.gnt0}), win ? 64'd2 : 64'd1);
    chk("c1_busy", 64'(bus.busy), 64'd1);
    chk("c1_ctrl", 64'(bus.alu_ctrl), 64'(op));
    chk("c1_ops", {bus.alu_a, bus.alu_b}, {a, b});
    // Winner drops its request and scribbles its operand lines.
    drive_port(win ? 1 : 0, 1'b0, 5'($urandom), $urandom, $urandom);
    for (int k = 2; k <= lat; k++) begin
      @(negedge clk);
      chk("exec_pulses", 64'({bus.gnt1, bus.gnt0, bus.done}), 64'd0);
      chk("exec_ctrl", 64'(bus.alu_ctrl), 64'(op));
      chk("exec_ops", {bus.alu_a, bus.alu_b}, {a, b});
      chk("exec_res", {bus.res_hi, bus.res_lo}, {exp_hi, exp_lo});
    end
    @(negedge clk);
    chk("done", 64'(bus.done), 64'd1);
    chk("done_id", 64'(bus.done_id), 64'(win));
    chk("err", 64'(bus.err), 64'(e));
    chk("res", {bus.res_hi, bus.res_lo}, {hi, lo});
    chk("done_alu", {27'd0, bus.alu_ctrl, bus.alu_a} | {32'd0, bus.alu_b}, 64'd0);
    chk("done_busy", 64'(bus.busy), 64'd1);
    exp_hi = hi;
    exp_lo = lo;
    @(negedge clk);
    chk("idle_flags", 64'({bus.done, bus.busy, bus.gnt0, bus.gnt1}), 64'd0);
    chk("idle_res", {bus.res_hi, bus.res_lo}, {exp_hi, exp_lo});
  endtask

  typedef struct {
    int          port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[8];

  logic        pend[2];
  logic [4:0]  p_op[2];
  logic [31:0] p_a[2];
  logic [31:0] p_b[2];
  logic        m_prio;

  initial begin
    tbl[0] = '{0, 5'd0,  32'd7,          32'd5,          1,       1'b0, 32'd0, 32'd12};
    tbl[1] = '{1, 5'd2,  32'h0001_0000,  32'h0001_0000,  MUL_CYC, 1'b0, 32'd1, 32'd0};
    tbl[2] = '{0, 5'd3,  32'd9,          32'd0,          1,       1'b1, 32'd0, 32'd0};
    tbl[3] = '{1, 5'd20, 32'd9,          32'd3,          1,       1'b1, 32'd0, 32'd0};
    tbl[4] = '{0, 5'd3,  32'd9,          32'd2,          DIV_CYC, 1'b0, 32'd1, 32'd4};
    tbl[5] = '{1, 5'd1,  32'd3,          32'd5,          1,       1'b0, 32'd0, 32'hFFFF_FFFE};
    tbl[6] = '{0, 5'd6,  32'd1,          32'd1,          1,       1'b0, 32'd0, 32'h8000_0000};
    tbl[7] = '{1, 5'd11, 32'd0,          32'd0,          1,       1'b0, 32'd0, 32'hFFFF_FFFF};

    // Reset with req0 asserted: everything stays zero, no grant.
    clr = 1'b0;
    drive_port(0, 1'b1, 5'd0, 32'd7, 32'd5);
    drive_port(1, 1'b0, 5'd0, 32'd0, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_flags", 64'({bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.err, bus.busy}), 64'd0);
      chk("rst_res", {bus.res_hi, bus.res_lo}, 64'd0);
      chk("rst_ctrl", 64'(bus.alu_ctrl), 64'd0);
      chk("rst_ops", {bus.alu_a, bus.alu_b}, 64'd0);
    end
    clr = 1'b1;
    check_txn(1'b0, 5'd0, 32'd7, 32'd5, 1, 1'b0, 32'd0, 32'd12);

    // Table-driven single-requester transactions.
    for (int i = 0; i < 8; i++) begin
      drive_port(tbl[i].port, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      check_txn(tbl[i].port[0], tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].err,
                tbl[i].hi, tbl[i].lo);
    end

    // Continuous contention from a fresh reset: grants 0,1,0,1 every 3 cycles.
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    drive_port(0, 1'b1, 5'd0, 32'd1, 32'd1);
    drive_port(1, 1'b1, 5'd0, 32'd1, 32'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c % 3 == 1) begin
        chk("cont_gnt", 64'({bus.gnt1, bus.gnt0}), (((c - 1) / 3) % 2 == 1) ? 64'd2 : 64'd1);
      end else begin
        chk("cont_nognt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
      end
      chk("cont_done", 64'(bus.done), (c % 3 == 2) ? 64'd1 : 64'd0);
      if (c % 3 == 2) begin
        chk("cont_done_id", 64'(bus.done_id), 64'(((c - 2) / 3) % 2));
        chk("cont_res", {bus.res_hi, bus.res_lo}, 64'd2);
      end
    end
    drive_port(0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive_port(1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    exp_lo = 32'd2;

    // Reset in cycle 4 of a divide: no done, then prio back at port 0.
    drive_port(0, 1'b1, 5'd3, 32'd9, 32'd2);
    @(posedge clk); @(negedge clk);
    chk("mid_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd1);
    drive_port(0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'({bus.busy, bus.done}), 64'd0);
    chk("mid_ctrl", 64'(bus.alu_ctrl), 64'd0);
    chk("mid_res", {bus.res_hi, bus.res_lo}, 64'd0);
    clr = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    begin
      int n_done;
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (bus.done) n_done++;
      end
      chk("mid_no_done", 64'(n_done), 64'd0);
    end
    drive_port(0, 1'b1, 5'd0, 32'd2, 32'd3);
    drive_port(1, 1'b1, 5'd0, 32'd4, 32'd5);
    check_txn(1'b0, 5'd0, 32'd2, 32'd3, 1, 1'b0, 32'd0, 32'd5);
    check_txn(1'b1, 5'd0, 32'd4, 32'd5, 1, 1'b0, 32'd0, 32'd9);

    // Randomised traffic against the round-robin reference.
    m_prio = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 60; r++) begin
      logic win;
      logic [63:0] z;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          int t;
          t = $urandom_range(0, 13);
          pend[p] = 1'b1;
          p_op[p] = (t > 11) ? 5'($urandom_range(12, 31)) : 5'(t);
          p_a[p] = $urandom;
          p_b[p] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
          drive_port(p, 1'b1, p_op[p], p_a[p], p_b[p]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        @(posedge clk); @(negedge clk);
        chk("rnd_quiet", 64'({bus.busy, bus.done, bus.gnt0, bus.gnt1}), 64'd0);
        chk("rnd_quiet_res", {bus.res_hi, bus.res_lo}, {exp_hi, exp_lo});
      end else begin
        win = (pend[0] && pend[1]) ? m_prio : pend[1];
        m_prio = ~win;
        z = ref_err(p_op[win], p_b[win]) ? 64'd0 : alu_fn(p_op[win], p_a[win], p_b[win]);
        check_txn(win, p_op[win], p_a[win], p_b[win], ref_lat(p_op[win], p_b[win]),
                  ref_err(p_op[win], p_b[win]), z[63:32], z[31:0]);
        pend[win] = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
